// File: rtl/uart_pkg.sv
// Shared UART types and defaults: FSM state encoding and character framing defaults.
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_W     = 8;
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first requester above last_grant, wrapping around.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant
);

  logic found;

  // Walk offsets 1..NUM_REQ from the last winner; the first pending requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (j == ((32'(last_grant) + k) % NUM_REQ))) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ requesters with round-robin grants.
// Frames are start bit, DATA_W data bits LSB first, one stop bit, each OVERSAMPLE
// ticks of the externally generated 16x uart_clk.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                         clock,
  input  logic                         Reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         uart_clk,
  output logic                         baud_enable,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_W);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

  tx_state_e          state_q;
  logic [1:0]         sync_q;
  logic               sync_prev_q;
  logic [TICK_W-1:0]  tick_cnt_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [DATA_W-1:0]  shift_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic [IDX_W-1:0]   grant_id_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic               tx_q;
  logic               baud_en_q;
  logic               busy_q;

  logic               tick_c;
  logic               tick_last_c;
  logic               any_req_c;
  logic               do_grant_c;
  logic [NUM_REQ-1:0] grant_oh_c;
  logic [IDX_W-1:0]   grant_idx_c;
  logic [DATA_W-1:0]  grant_byte_c;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant_oh_c)
  );

  // Rising edge of the synchronized baud clock, and the winner's index and byte.
  always_comb begin
    tick_c       = sync_q[1] & ~sync_prev_q;
    tick_last_c  = tick_c && (tick_cnt_q == TICK_LAST);
    any_req_c    = |req_valid;
    do_grant_c   = any_req_c &&
                   ((state_q == ST_IDLE) || ((state_q == ST_STOP) && tick_last_c));
    grant_idx_c  = '0;
    grant_byte_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh_c[i]) begin
        grant_idx_c  = IDX_W'(i);
        grant_byte_c = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Synchronizer, frame FSM and registered outputs; a grant from IDLE or the last
  // STOP tick starts a new frame immediately so back-to-back frames have no gap.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      sync_q       <= 2'b11;
      sync_prev_q  <= 1'b1;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      last_grant_q <= IDX_LAST;
      grant_id_q   <= '0;
      req_ready_q  <= '0;
      tx_q         <= 1'b1;
      baud_en_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], uart_clk};
      sync_prev_q <= sync_q[1];
      req_ready_q <= '0;
      if (do_grant_c) begin
        state_q      <= ST_START;
        shift_q      <= grant_byte_c;
        req_ready_q  <= grant_oh_c;
        last_grant_q <= grant_idx_c;
        grant_id_q   <= grant_idx_c;
        baud_en_q    <= 1'b1;
        busy_q       <= 1'b1;
        tx_q         <= 1'b0;
        tick_cnt_q   <= '0;
        bit_cnt_q    <= '0;
      end else if (tick_c) begin
        case (state_q)
          ST_START: begin
            if (tick_last_c) begin
              state_q    <= ST_DATA;
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              tx_q       <= shift_q[0];
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          ST_DATA: begin
            if (tick_last_c) begin
              tick_cnt_q <= '0;
              if (bit_cnt_q == BIT_LAST) begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                shift_q   <= shift_q >> 1;
                tx_q      <= shift_q[1];
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          ST_STOP: begin
            if (tick_last_c) begin
              state_q    <= ST_IDLE;
              tick_cnt_q <= '0;
              tx_q       <= 1'b1;
              baud_en_q  <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign req_ready   = req_ready_q;
  assign tx          = tx_q;
  assign baud_enable = baud_en_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: a line decoder rebuilds frames from tx,
// and a round-robin model predicts which requester and byte each frame carries.
module tb_uart_tx_scheduler;

  localparam int NR = 4;

  logic          clock = 1'b0;
  logic          Reset = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic          uart_clk = 1'b1;
  logic          baud_enable, tx, busy;
  logic [1:0]    grant_id;

  uart_tx_scheduler #(.NUM_REQ(NR), .DATA_W(8), .OVERSAMPLE(16)) dut (
    .clock(clock), .Reset(Reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_clk(uart_clk), .baud_enable(baud_enable),
    .tx(tx), .busy(busy), .grant_id(grant_id)
  );

  typedef struct {
    int         id;
    logic [7:0] data;
    bit         start_ok;
    bit         stop_ok;
    int         len;
  } frame_t;

  int checks = 0;
  int errors = 0;
  bit uart_run = 1'b1;
  int utick = 0;
  int bad_ready = 0;
  int be_fall = 0;
  int model_last = NR - 1;

  logic [7:0] src_mem [NR][16];
  int src_head [NR];
  int src_tail [NR];
  frame_t mon_q [$];
  int ready_log [$];
  int exp_id [$];
  logic [7:0] exp_data [$];

  // 50 MHz system clock; baud clock edges offset so they never coincide with clock edges.
  always #10 clock = ~clock;
  initial begin
    #5;
    forever begin
      #50;
      uart_clk = uart_run ? ~uart_clk : 1'b1;
    end
  end
  initial forever begin
    @(posedge uart_clk);
    utick++;
  end

  // Requester agents: present the head of each queue, retire it on req_ready.
  initial begin
    for (int i = 0; i < NR; i++) begin src_head[i] = 0; src_tail[i] = 0; end
    forever begin
      @(negedge clock);
      if ($countones(req_ready) > 1) bad_ready++;
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i] === 1'b1) begin
          ready_log.push_back(i);
          if (src_tail[i] > src_head[i]) src_head[i]++;
        end
      end
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = (src_tail[i] > src_head[i]);
        req_data[i*8 +: 8] = (src_tail[i] > src_head[i]) ? src_mem[i][src_head[i] % 16] : 8'h00;
      end
    end
  end

  // baud_enable falling-edge counter.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clock);
      if (prev === 1'b1 && baud_enable === 1'b0) be_fall++;
      prev = baud_enable;
    end
  end

  // Line decoder: samples mid-bit by counting baud clock edges from the start edge.
  initial begin
    frame_t fr;
    int s;
    @(negedge clock);
    forever begin
      while (tx !== 1'b0) @(negedge clock);
      s = utick;
      fr.id = int'(grant_id);
      fr.data = '0;
      repeat (8) @(posedge uart_clk);
      fr.start_ok = (tx === 1'b0);
      for (int b = 0; b < 8; b++) begin
        repeat (16) @(posedge uart_clk);
        fr.data[b] = tx;
      end
      repeat (16) @(posedge uart_clk);
      fr.stop_ok = (tx === 1'b1);
      @(negedge clock);
      while (tx === 1'b1 && busy === 1'b1) @(negedge clock);
      fr.len = utick - s;
      mon_q.push_back(fr);
    end
  end

  function automatic void push_src(input int r, input logic [7:0] b);
    src_mem[r][src_tail[r] % 16] = b;
    src_tail[r]++;
  endfunction

  // Round-robin reference: repeatedly serve the next pending requester after the last one.
  function automatic void predict();
    int cnt [NR];
    int ptr [NR];
    bit found;
    for (int i = 0; i < NR; i++) begin
      cnt[i] = src_tail[i] - src_head[i];
      ptr[i] = src_head[i];
    end
    for (int n = 0; n < 64; n++) begin
      found = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        int j;
        j = (model_last + k) % NR;
        if (!found && cnt[j] > 0) begin
          exp_id.push_back(j);
          exp_data.push_back(src_mem[j][ptr[j] % 16]);
          ptr[j]++;
          cnt[j]--;
          model_last = j;
          found = 1'b1;
        end
      end
      if (!found) break;
    end
  endfunction

  function automatic void clear_logs();
    mon_q.delete();
    ready_log.delete();
    exp_id.delete();
    exp_data.delete();
  endfunction

  task automatic do_reset();
    @(negedge clock);
    Reset = 1'b1;
    repeat (2) @(negedge clock);
    Reset = 1'b0;
    model_last = NR - 1;
  endtask

  task automatic wait_done(input int n, output bit ok);
    int cyc;
    cyc = 0;
    @(negedge clock);
    while ((mon_q.size() < n || busy !== 1'b0) && cyc < n * 1000 + 500) begin
      @(negedge clock);
      cyc++;
    end
    ok = (mon_q.size() >= n) && (busy === 1'b0);
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (baud_enable !== 1'b0) begin errors++; $display("FAIL reset_baud got=%b exp=0", baud_enable); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    push_src(0, 8'h55);
    predict();
    wait_done(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout frames=%0d busy=%b exp 1 frame idle", mon_q.size(), busy); end
    for (int k = 0; k < exp_id.size() && k < mon_q.size(); k++) begin
      checks++;
      if (mon_q[k].id !== exp_id[k] || mon_q[k].data !== exp_data[k] || !mon_q[k].start_ok ||
          !mon_q[k].stop_ok || mon_q[k].len < 159 || mon_q[k].len > 161) begin
        errors++;
        $display("FAIL single_frame%0d id=%0d data=%h start=%b stop=%b len=%0d exp id=%0d data=%h len=160",
                 k, mon_q[k].id, mon_q[k].data, mon_q[k].start_ok, mon_q[k].stop_ok, mon_q[k].len, exp_id[k], exp_data[k]);
      end
    end
    checks++; if (ready_log.size() != 1 || ready_log[0] != 0) begin errors++; $display("FAIL single_ready pulses=%0d exp 1 on requester 0", ready_log.size()); end
    checks++; if (tx !== 1'b1 || baud_enable !== 1'b0) begin errors++; $display("FAIL single_idle tx=%b baud=%b exp tx=1 baud=0", tx, baud_enable); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int f0;
    do_reset();
    clear_logs();
    push_src(0, 8'hA0); push_src(0, 8'hA4);
    push_src(1, 8'hA1); push_src(2, 8'hA2); push_src(3, 8'hA3);
    predict();
    f0 = be_fall;
    wait_done(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout frames=%0d exp 5", mon_q.size()); end
    for (int k = 0; k < exp_id.size() && k < mon_q.size(); k++) begin
      checks++;
      if (mon_q[k].id !== exp_id[k] || mon_q[k].data !== exp_data[k] || !mon_q[k].start_ok ||
          !mon_q[k].stop_ok || mon_q[k].len < 159 || mon_q[k].len > 161) begin
        errors++;
        $display("FAIL b2b_frame%0d id=%0d data=%h start=%b stop=%b len=%0d exp id=%0d data=%h len=160",
                 k, mon_q[k].id, mon_q[k].data, mon_q[k].start_ok, mon_q[k].stop_ok, mon_q[k].len, exp_id[k], exp_data[k]);
      end
    end
    checks++; if (be_fall - f0 != 1) begin errors++; $display("FAIL b2b_baud_drops got=%0d exp=1", be_fall - f0); end
    checks++; if (ready_log.size() != 5) begin errors++; $display("FAIL b2b_ready_count got=%0d exp=5", ready_log.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    clear_logs();
    push_src(2, 8'h3C);
    predict();
    wait_done(1, ok);
    push_src(0, 8'h81);
    push_src(2, 8'h7E);
    predict();
    wait_done(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout frames=%0d exp 3", mon_q.size()); end
    for (int k = 0; k < exp_id.size() && k < mon_q.size(); k++) begin
      checks++;
      if (mon_q[k].id !== exp_id[k] || mon_q[k].data !== exp_data[k] || !mon_q[k].start_ok || !mon_q[k].stop_ok) begin
        errors++;
        $display("FAIL wrap_frame%0d id=%0d data=%h exp id=%0d data=%h", k, mon_q[k].id, mon_q[k].data, exp_id[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_withdraw();
    bit ok;
    clear_logs();
    push_src(0, 8'hC3);
    predict();
    repeat (100) @(negedge clock);
    push_src(1, 8'h11);
    repeat (50) @(negedge clock);
    src_tail[1] = src_head[1];
    wait_done(1, ok);
    repeat (100) @(negedge clock);
    checks++; if (!ok) begin errors++; $display("FAIL withdraw_timeout frames=%0d exp 1", mon_q.size()); end
    checks++;
    if (ready_log.size() != 1 || mon_q.size() != 1 || ready_log[0] != 0) begin
      errors++; $display("FAIL withdraw_grants ready=%0d frames=%0d exp 1 grant to requester 0 only", ready_log.size(), mon_q.size());
    end
    checks++; if (mon_q.size() > 0 && mon_q[0].data !== 8'hC3) begin errors++; $display("FAIL withdraw_data got=%h exp=c3", mon_q[0].data); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    int cyc;
    clear_logs();
    push_src(0, 8'hFF);
    cyc = 0;
    while (busy !== 1'b1 && cyc < 100) begin @(negedge clock); cyc++; end
    repeat (48) @(posedge uart_clk);
    @(negedge clock);
    Reset = 1'b1;
    @(negedge clock);
    checks++; if (tx !== 1'b1 || baud_enable !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_outputs tx=%b baud=%b busy=%b exp 1 0 0", tx, baud_enable, busy);
    end
    Reset = 1'b0;
    model_last = NR - 1;
    repeat (250) @(posedge uart_clk);
    @(negedge clock);
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL abort_no_retx busy=%b tx=%b exp 0 1", busy, tx); end
    clear_logs();
    push_src(3, 8'($urandom));
    predict();
    wait_done(1, ok);
    checks++;
    if (!ok || mon_q.size() != 1 || mon_q[0].id != 3 || mon_q[0].data !== exp_data[0] ||
        !mon_q[0].stop_ok || mon_q[0].len < 159 || mon_q[0].len > 161) begin
      errors++; $display("FAIL abort_next_frame frames=%0d exp one frame id=3 data=%h", mon_q.size(), exp_data[0]);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int bad;
    int cyc;
    clear_logs();
    push_src(0, 8'($urandom));
    predict();
    cyc = 0;
    while (tx !== 1'b0 && cyc < 100) begin @(negedge clock); cyc++; end
    repeat (4) @(posedge uart_clk);
    uart_run = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clock);
      if (tx !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd0 || baud_enable !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold bad_cycles=%0d exp=0", bad); end
    uart_run = 1'b1;
    wait_done(1, ok);
    checks++;
    if (!ok || mon_q.size() != 1 || mon_q[0].data !== exp_data[0] || !mon_q[0].start_ok || !mon_q[0].stop_ok) begin
      errors++; $display("FAIL stall_resume frames=%0d exp data=%h", mon_q.size(), exp_data[0]);
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    for (int r = 0; r < 3; r++) begin
      clear_logs();
      n = 0;
      for (int i = 0; i < NR; i++) begin
        int c;
        c = $urandom_range(0, 2);
        if (i == r) c = c + 1;
        for (int j = 0; j < c; j++) push_src(i, 8'($urandom));
      end
      predict();
      n = exp_id.size();
      wait_done(n, ok);
      checks++; if (!ok || mon_q.size() != n) begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, mon_q.size(), n); end
      for (int k = 0; k < n && k < mon_q.size(); k++) begin
        checks++;
        if (mon_q[k].id !== exp_id[k] || mon_q[k].data !== exp_data[k] || !mon_q[k].start_ok ||
            !mon_q[k].stop_ok || mon_q[k].len < 159 || mon_q[k].len > 161 ||
            k >= ready_log.size() || ready_log[k] != exp_id[k]) begin
          errors++;
          $display("FAIL rand%0d_frame%0d id=%0d data=%h len=%0d exp id=%0d data=%h len=160",
                   r, k, mon_q[k].id, mon_q[k].data, mon_q[k].len, exp_id[k], exp_data[k]);
        end
      end
    end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL ready_onehot bad=%0d exp=0", bad_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_withdraw();
    test_reset_abort();
    test_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the transmitter.
REQ-002 SHALL have parameter DATA_W, default 8: bits per character.
REQ-003 SHALL have parameter OVERSAMPLE, default 16: uart_clk rising edges per bit.
REQ-004 SHALL have port clock, input, 1: system clock; all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port req_valid, input, NUM_REQ: per-requester "byte pending".
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_W: requester i's byte in bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_ready, output, NUM_REQ: one-cycle, one-hot acceptance pulse.
REQ-009 SHALL have port uart_clk, input, 1: 16x bit-rate clock from the baud generator; asynchronous to clock, idles high when baud generation is disabled.
REQ-010 SHALL have port baud_enable, output, 1: enable for the baud generator.
REQ-011 SHALL have port tx, output, 1: serial line, idle high.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have port grant_id, output, clog2(NUM_REQ): index of the requester currently being transmitted.

Function
REQ-014 SHALL pass uart_clk through a 2-flop synchronizer; tick = one-cycle pulse on a 0->1 transition of the synchronized signal.
REQ-015 SHALL implement states IDLE, START, DATA, STOP.
REQ-016 IDLE: tx=1, baud_enable=0; when any req_valid is high, SHALL grant round-robin, searching from last_grant+1 upward with wrap-around.
REQ-017 On grant, SHALL in the same cycle latch the granted byte, pulse req_ready[grant], update last_grant and grant_id, set baud_enable=1, and enter START.
REQ-018 START SHALL drive tx=0 for OVERSAMPLE ticks, then enter DATA.
REQ-019 DATA SHALL shift out DATA_W bits LSB first, each held for OVERSAMPLE ticks, then enter STOP.
REQ-020 STOP SHALL drive tx=1 for OVERSAMPLE ticks.
REQ-021 On the final STOP tick with any req_valid high, SHALL grant per REQ-016/017 and enter START directly with baud_enable held at 1. Otherwise it SHALL enter IDLE and drop baud_enable.
REQ-022 Tick counter SHALL be clog2(OVERSAMPLE) bits, cleared on every state entry; bit counter SHALL be clog2(DATA_W) bits and wrap.
REQ-023 Handshake: a requester SHALL hold req_valid and req_data stable until its req_ready. Deasserting req_valid before grant withdraws the request. req_valid changes after grant SHALL not affect the frame in flight.
REQ-024 Grant decisions SHALL be made only in IDLE or on the final STOP tick; requests arriving mid-frame wait.
REQ-025 tx, busy and grant_id SHALL be registered outputs (glitch-free).
REQ-026 If no tick arrives, the FSM SHALL hold its state indefinitely; no timeout.

Reset
REQ-027 Reset SHALL force state=IDLE, tx=1, baud_enable=0, busy=0, req_ready=0, grant_id=0, counters=0, synchronizer flops=1.
REQ-028 Reset SHALL set last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-029 Reset mid-frame SHALL abort the frame: tx goes to 1 on the next edge and the aborted byte is not retransmitted.

Structure
REQ-030 State encoding and OVERSAMPLE/DATA_W defaults SHALL live in shared package uart_pkg.
REQ-031 The round-robin selector SHALL be sub-module rr_arbiter (inputs req and last_grant; output one-hot grant), combinational; all other logic in uart_tx_scheduler.
REQ-032 The baud generator SHALL be instantiated by the parent, not inside this block.

Verification
REQ-033 Reset, then req_valid=4'b0001 with byte 0x55 -> req_ready[0] pulses once; tx = 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each 16 ticks; busy falls after stop.
REQ-034 req_valid=4'b1111 held, bytes 0xA0..0xA3 -> grant order 0,1,2,3,0; frames back-to-back with no idle gap; baud_enable never drops.
REQ-035 After requester 2 served, req_valid=4'b0101 -> grant_id=0 (wrap-around), then 2.
REQ-036 Reset asserted mid-DATA on byte 0xFF -> tx=1 and baud_enable=0 on the next cycle; the next request from requester 3 is granted normally with a full frame.
REQ-037 req_valid[1] pulsed then dropped while busy -> no grant to 1; req_ready stays 0.
REQ-038 Stop toggling uart_clk mid-START for 1000 cycles -> tx held at 0, state unchanged; frame completes correctly once toggling resumes.
